// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI mode-0 master: FSM state encoding and default frame/divider sizes.
package spi_master_pkg;

    // Default frame length; the matching spi_slave uses the same default.
    localparam int unsigned SPI_WIDTH  = 8;
    // Default number of clk cycles per sclk half-period.
    localparam int unsigned SPI_CLKDIV = 4;

    // Frame sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_e;

    // Bit counter width: one spare bit so the counter never wraps within a frame.
    function automatic int unsigned bit_cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/spi_master_clk_div.sv
// Phase timer for the SPI master: counts 0..CLKDIV-1 while enabled and flags the
// last count of each phase so the FSM can move sclk on the following edge.
module spi_master_clk_div #(
    parameter int unsigned CLKDIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tick_c
);

    localparam int unsigned CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    logic [CW-1:0] r_cnt;

    assign o_tick_c = i_en && (r_cnt == CW'(CLKDIV - 1));

    // Phase counter: held at zero while disabled, wraps to zero on each tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!i_en || o_tick_c) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master (CPOL=0, CPHA=0): one WIDTH-bit frame per accepted start.
// Build option: SPI_MASTER_LSB_FIRST_EN selects LSB-first frames (default MSB first);
// timing is identical in both builds.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int unsigned WIDTH  = SPI_WIDTH,
    parameter int unsigned CLKDIV = SPI_CLKDIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy,
    output logic             done,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso,
    output logic             ss
);

    localparam int unsigned BW = bit_cnt_width(WIDTH);

    spi_state_e       r_state;
    logic [WIDTH-1:0] r_tx_sh;
    logic [WIDTH-1:0] r_rx_sh;
    logic [WIDTH-1:0] r_rx_data;
    logic [BW-1:0]    r_bit_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_sclk;
    logic             r_ss;

    logic             w_tick;
    logic [WIDTH-1:0] w_tx_next;
    logic [WIDTH-1:0] w_rx_next;
    logic             w_mosi;

    // Phase timer runs only while a frame is in flight.
    spi_master_clk_div #(
        .CLKDIV (CLKDIV)
    ) u_clk_div (
        .clk      (clk),
        .rst      (rst),
        .i_en     (r_busy),
        .o_tick_c (w_tick)
    );

`ifdef SPI_MASTER_LSB_FIRST_EN
    // LSB first: bit0 leaves first, first sampled bit ends up in bit0.
    assign w_tx_next = {1'b0, r_tx_sh[WIDTH-1:1]};
    assign w_rx_next = {miso, r_rx_sh[WIDTH-1:1]};
    assign w_mosi    = r_tx_sh[0];
`else
    // MSB first: top bit leaves first, first sampled bit ends up in the MSB.
    assign w_tx_next = {r_tx_sh[WIDTH-2:0], 1'b0};
    assign w_rx_next = {r_rx_sh[WIDTH-2:0], miso};
    assign w_mosi    = r_tx_sh[WIDTH-1];
`endif

    // mosi is taken straight from a shift-register flop, so it stays registered
    // and holds the last bit until the next frame reloads the register.
    assign mosi    = w_mosi;
    assign sclk    = r_sclk;
    assign ss      = r_ss;
    assign busy    = r_busy;
    assign done    = r_done;
    assign rx_data = r_rx_data;

    // Frame sequencer: sclk toggles and bits advance only on phase-timer ticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_tx_sh   <= '0;
            r_rx_sh   <= '0;
            r_rx_data <= '0;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_ss      <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_tx_sh   <= tx_data;
                        r_rx_sh   <= '0;
                        r_bit_cnt <= '0;
                        r_ss      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    // First rising edge: sample the first miso bit.
                    if (w_tick) begin
                        r_sclk  <= 1'b1;
                        r_rx_sh <= w_rx_next;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        if (r_sclk) begin
                            // Falling edge: advance mosi unless this was the last bit.
                            r_sclk <= 1'b0;
                            if (r_bit_cnt == BW'(WIDTH - 1)) begin
                                r_state <= ST_HOLD;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + BW'(1);
                                r_tx_sh   <= w_tx_next;
                            end
                        end else begin
                            // Rising edge: capture miso.
                            r_sclk  <= 1'b1;
                            r_rx_sh <= w_rx_next;
                        end
                    end
                end
                ST_HOLD: begin
                    // ss held low for one more phase, then the frame completes.
                    if (w_tick) begin
                        r_ss      <= 1'b1;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_rx_data <= r_rx_sh;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed self-checking bench for spi_master (WIDTH=8, CLKDIV=4) with a
// behavioural mode-0 slave on the far end of the link.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       busy;
    logic       done;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       ss;

    int errors = 0;
    int checks = 0;

    // Observations from the most recent observe() window.
    int         o_done_cnt;
    int         o_done_t1;
    int         o_done_t2;
    int         o_rises;
    int         o_gap;
    logic [7:0] o_mosi_seq;
    logic [7:0] o_slv_rx;

    always #5 clk = ~clk;

    spi_master #(
        .WIDTH  (8),
        .CLKDIV (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .tx_data (tx_data),
        .rx_data (rx_data),
        .busy    (busy),
        .done    (done),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso),
        .ss      (ss)
    );

    // Wire position of the i-th transferred bit.
    function automatic int pos(input int i);
`ifdef SPI_MASTER_LSB_FIRST_EN
        return i;
`else
        return 7 - i;
`endif
    endfunction

    function automatic logic bit_at(input logic [7:0] v, input int i);
        return v[3'(pos(i))];
    endfunction

    // Runs ncyc cycles from E0 (the edge that accepts start), playing the slave.
    // Sample t observes the state after edge E0+t.
    task automatic observe(input int ncyc, input logic [7:0] slv_tx,
                           input int p1, input int p2, input bit hold);
        logic prev_sclk;
        logic prev_ss;
        int   idx;
        int   ridx;
        o_done_cnt = 0;
        o_done_t1  = -1;
        o_done_t2  = -1;
        o_rises    = 0;
        o_gap      = 0;
        o_mosi_seq = '0;
        o_slv_rx   = '0;
        prev_sclk  = 1'b0;
        prev_ss    = 1'b1;
        idx        = 0;
        ridx       = 0;
        @(posedge clk);
        for (int t = 0; t < ncyc; t++) begin
            @(negedge clk);
            start = (hold && t < 100) || (t == p1) || (t == p2);
            if (t == 5) tx_data = ~tx_data;
            if (prev_ss && !ss) begin
                idx  = 0;
                ridx = 0;
                miso = bit_at(slv_tx, 0);
            end
            if (!prev_sclk && sclk) begin
                if (o_rises < 8) o_mosi_seq[3'(o_rises)] = mosi;
                o_rises++;
                if (ridx < 8) o_slv_rx[3'(pos(ridx))] = mosi;
                ridx++;
            end
            if (prev_sclk && !sclk) begin
                idx++;
                if (idx < 8) miso = bit_at(slv_tx, idx);
            end
            if (done) begin
                o_done_cnt++;
                if (o_done_cnt == 1) o_done_t1 = t;
                else if (o_done_cnt == 2) o_done_t2 = t;
            end
            if (o_done_cnt == 1 && ss) o_gap++;
            prev_sclk = sclk;
            prev_ss   = ss;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        start   = 1'b1;
        tx_data = 8'h3C;
        miso    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({ss, sclk, busy, done, mosi} !== 5'b10000) begin
                errors++;
                $display("FAIL reset_ctrl cyc%0d: {ss,sclk,busy,done,mosi}=%b expected 10000", i,
                         {ss, sclk, busy, done, mosi});
            end
            checks++;
            if (rx_data !== 8'h00) begin
                errors++;
                $display("FAIL reset_rx cyc%0d: rx_data=%h expected 00", i, rx_data);
            end
        end
        rst = 1'b1;
        observe(80, 8'h81, -1, -1, 1'b0);
        checks++;
        if (o_done_t1 !== 68) begin
            errors++;
            $display("FAIL reset_first_frame: done at E0+%0d expected E0+68", o_done_t1);
        end
        checks++;
        if (rx_data !== 8'h81) begin
            errors++;
            $display("FAIL reset_first_rx: rx_data=%h expected 81", rx_data);
        end
    endtask

    task automatic test_frame();
        logic [7:0] exp_seq;
        exp_seq = 8'b10100101;
        tx_data = 8'hA5;
        start   = 1'b1;
        observe(80, 8'h3C, -1, -1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (o_mosi_seq[3'(i)] !== exp_seq[3'(7 - i)]) begin
                errors++;
                $display("FAIL frame_mosi rise%0d: got %b expected %b", i,
                         o_mosi_seq[3'(i)], exp_seq[3'(7 - i)]);
            end
        end
        checks++;
        if (o_done_t1 !== 68) begin
            errors++;
            $display("FAIL frame_done_time: E0+%0d expected E0+68", o_done_t1);
        end
        checks++;
        if (o_done_cnt !== 1) begin
            errors++;
            $display("FAIL frame_done_count: %0d expected 1", o_done_cnt);
        end
        checks++;
        if (o_rises !== 8) begin
            errors++;
            $display("FAIL frame_rises: %0d expected 8", o_rises);
        end
        checks++;
        if (rx_data !== 8'h3C) begin
            errors++;
            $display("FAIL frame_rx: rx_data=%h expected 3c", rx_data);
        end
        checks++;
        if ({busy, ss, sclk} !== 3'b010) begin
            errors++;
            $display("FAIL frame_idle: {busy,ss,sclk}=%b expected 010", {busy, ss, sclk});
        end
    endtask

    task automatic test_loopback();
        tx_data = 8'hC3;
        start   = 1'b1;
        observe(80, 8'h55, -1, -1, 1'b0);
        checks++;
        if (rx_data !== 8'h55) begin
            errors++;
            $display("FAIL loop_master_rx: rx_data=%h expected 55", rx_data);
        end
        checks++;
        if (o_slv_rx !== 8'hC3) begin
            errors++;
            $display("FAIL loop_slave_rx: slave rx=%h expected c3", o_slv_rx);
        end
    endtask

    task automatic test_start_ignored();
        tx_data = 8'h96;
        start   = 1'b1;
        observe(90, 8'h69, 10, 40, 1'b0);
        checks++;
        if (o_done_cnt !== 1) begin
            errors++;
            $display("FAIL ignore_done_count: %0d expected 1", o_done_cnt);
        end
        checks++;
        if (o_done_t1 !== 68) begin
            errors++;
            $display("FAIL ignore_done_time: E0+%0d expected E0+68", o_done_t1);
        end
        checks++;
        if (busy !== 1'b0 || rx_data !== 8'h69) begin
            errors++;
            $display("FAIL ignore_end: busy=%b rx_data=%h expected 0 69", busy, rx_data);
        end
    endtask

    task automatic test_back_to_back();
        tx_data = 8'h0F;
        start   = 1'b1;
        observe(145, 8'hE7, -1, -1, 1'b1);
        checks++;
        if (o_done_cnt !== 2) begin
            errors++;
            $display("FAIL b2b_done_count: %0d expected 2", o_done_cnt);
        end
        checks++;
        if (o_done_t1 !== 68 || o_done_t2 !== 137) begin
            errors++;
            $display("FAIL b2b_done_times: E0+%0d,E0+%0d expected E0+68,E0+137",
                     o_done_t1, o_done_t2);
        end
        checks++;
        if (o_gap !== 1) begin
            errors++;
            $display("FAIL b2b_ss_gap: ss high %0d cycles expected 1", o_gap);
        end
        checks++;
        if (rx_data !== 8'hE7 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: rx_data=%h busy=%b expected e7 0", rx_data, busy);
        end
    endtask

    task automatic test_abort();
        int ndone;
        tx_data = 8'hF0;
        start   = 1'b1;
        miso    = 1'b1;
        @(posedge clk);
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++;
        if (busy !== 1'b1 || ss !== 1'b0) begin
            errors++;
            $display("FAIL abort_midframe: busy=%b ss=%b expected 1 0", busy, ss);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({ss, sclk, busy, done, mosi} !== 5'b10000 || rx_data !== 8'h00) begin
            errors++;
            $display("FAIL abort_async: {ss,sclk,busy,done,mosi}=%b rx=%h expected 10000 00",
                     {ss, sclk, busy, done, mosi}, rx_data);
        end
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        rst = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: done pulses=%0d busy=%b expected 0 0", ndone, busy);
        end
        tx_data = 8'h5A;
        start   = 1'b1;
        observe(80, 8'hA6, -1, -1, 1'b0);
        checks++;
        if (o_done_t1 !== 68 || rx_data !== 8'hA6 || o_slv_rx !== 8'h5A) begin
            errors++;
            $display("FAIL abort_next_frame: t=%0d rx=%h slave=%h expected 68 a6 5a",
                     o_done_t1, rx_data, o_slv_rx);
        end
    endtask

    task automatic test_bit_order();
        logic [7:0] exp_seq;
`ifdef SPI_MASTER_LSB_FIRST_EN
        exp_seq = 8'h01;
`else
        exp_seq = 8'h80;
`endif
        tx_data = 8'h01;
        start   = 1'b1;
        observe(80, 8'h01, -1, -1, 1'b0);
        checks++;
        if (o_mosi_seq !== exp_seq) begin
            errors++;
            $display("FAIL order_mosi: rise-ordered bits=%b expected %b", o_mosi_seq, exp_seq);
        end
        checks++;
        if (rx_data !== 8'h01) begin
            errors++;
            $display("FAIL order_rx: rx_data=%h expected 01", rx_data);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_loopback();
        test_start_ignored();
        test_back_to_back();
        test_abort();
        test_bit_order();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
